// File: rtl/mmap_read_arbiter.sv
// Round-robin arbiter sharing the read side of one async_mmap among NumPorts requesters.
// An order queue of granted port ids steers in-order read beats back to their originating port.
module mmap_read_arbiter #(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned PortIdWidth    = 2,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned TagDepth       = 64,
  parameter int unsigned TagDepthLog    = 6,
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned CntWidth       = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumPorts*AddrWidth-1:0] req_addr_dout,
  input  logic [NumPorts-1:0]           req_addr_empty_n,
  output logic [NumPorts-1:0]           req_addr_read,
  output logic [DataWidth-1:0]          resp_data_dout,
  output logic [NumPorts-1:0]           resp_data_empty_n,
  input  logic [NumPorts-1:0]           resp_data_read,
  output logic [AddrWidth-1:0]          read_addr_din,
  output logic                          read_addr_write,
  input  logic                          read_addr_full_n,
  input  logic [DataWidth-1:0]          read_data_dout,
  input  logic                          read_data_empty_n,
  output logic                          read_data_read
);

  logic                   out_valid;
  logic [AddrWidth-1:0]   out_addr;
  logic [PortIdWidth-1:0] rr_ptr;
  logic [PortIdWidth-1:0] order_mem [TagDepth];
  logic [TagDepthLog-1:0] wr_ptr;
  logic [TagDepthLog-1:0] rd_ptr;
  logic [TagDepthLog:0]   count;
  logic [CntWidth-1:0]    outstanding [NumPorts];

  logic [NumPorts-1:0]    eligible;
  logic                   cap;
  logic                   grant;
  logic [PortIdWidth-1:0] grant_idx;
  logic [PortIdWidth-1:0] next_rr;
  logic [AddrWidth-1:0]   grant_addr;
  logic [PortIdWidth-1:0] head;
  logic                   hv;
  logic                   pop;
  logic [NumPorts-1:0]    inc_vec;
  logic [NumPorts-1:0]    dec_vec;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      eligible[i] = req_addr_empty_n[i] && (outstanding[i] < CntWidth'(MaxOutstanding));
    end
  end

  // Full check uses the pre-pop count, so a simultaneous pop never lets a grant in at full.
  assign cap = (!out_valid || read_addr_full_n) && (count < (TagDepthLog + 1)'(TagDepth));

  always_comb begin
    logic [PortIdWidth-1:0] idx;
    idx       = '0;
    grant     = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      idx = PortIdWidth'((32'(rr_ptr) + k) % NumPorts);
      if (!rst && cap && !grant && eligible[idx]) begin
        grant     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign next_rr = PortIdWidth'((32'(grant_idx) + 32'd1) % NumPorts);

  always_comb begin
    grant_addr    = '0;
    req_addr_read = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (grant_idx == PortIdWidth'(i)) begin
        grant_addr       = req_addr_dout[i*AddrWidth +: AddrWidth];
        req_addr_read[i] = grant;
      end
    end
  end

  assign read_addr_write = out_valid;
  assign read_addr_din   = out_addr;

  assign head           = order_mem[rd_ptr];
  assign hv             = (count != '0) && read_data_empty_n;
  assign pop            = hv && resp_data_read[head];
  assign read_data_read = pop;
  assign resp_data_dout = read_data_dout;

  always_comb begin
    resp_data_empty_n = '0;
    inc_vec           = '0;
    dec_vec           = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      resp_data_empty_n[i] = hv && (head == PortIdWidth'(i));
      inc_vec[i]           = grant && (grant_idx == PortIdWidth'(i));
      dec_vec[i]           = pop && (head == PortIdWidth'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        outstanding[i] <= '0;
      end
    end else begin
      if (grant) begin
        out_valid <= 1'b1;
        out_addr  <= grant_addr;
        rr_ptr    <= next_rr;
        wr_ptr    <= wr_ptr + 1'b1;
      end else if (read_addr_full_n) begin
        out_valid <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (grant && !pop) begin
        count <= count + 1'b1;
      end else if (!grant && pop) begin
        count <= count - 1'b1;
      end
      for (int unsigned i = 0; i < NumPorts; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   outstanding[i] <= outstanding[i] + 1'b1;
          2'b01:   outstanding[i] <= outstanding[i] - 1'b1;
          default: outstanding[i] <= outstanding[i];
        endcase
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (grant) begin
      order_mem[wr_ptr] <= grant_idx;
    end
  end

endmodule

// File: doc/mmap_read_arbiter.md
Name: mmap_read_arbiter

Overview:
- Shares the read side of one async_mmap instance among NumPorts independent requesters.
- Pops per-port read-address FIFOs with round-robin arbitration and forwards one address per grant to async_mmap's read_addr push interface through a registered issue stage.
- Records each grant's port index in an internal order queue so returned read_data beats (one beat per address, in order) are steered back to the originating port.
- Caps outstanding requests per port.

Parameters:
- NumPorts, 4, number of requesters.
- PortIdWidth, 2, log2(NumPorts), minimum 1.
- AddrWidth, 64, byte address width.
- DataWidth, 512, read data width.
- TagDepth, 64, order-queue depth; equals async_mmap BufferSize.
- TagDepthLog, 6, log2(TagDepth).
- MaxOutstanding, 16, per-port cap on granted-but-unreturned beats; range 1..TagDepth.
- CntWidth, 5, width of per-port outstanding counter; must hold MaxOutstanding.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_addr_dout  in  NumPorts*AddrWidth  per-port address; port i is at [i*AddrWidth +: AddrWidth].
- req_addr_empty_n  in  NumPorts  per-port address valid.
- req_addr_read  out  NumPorts  per-port pop; one-hot or zero.
- resp_data_dout  out  DataWidth  response data, broadcast to all ports.
- resp_data_empty_n  out  NumPorts  per-port response valid.
- resp_data_read  in  NumPorts  per-port response pop.
- read_addr_din  out  AddrWidth  to async_mmap.
- read_addr_write  out  1  to async_mmap.
- read_addr_full_n  in  1  from async_mmap.
- read_data_dout  in  DataWidth  from async_mmap.
- read_data_empty_n  in  1  from async_mmap.
- read_data_read  out  1  to async_mmap.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_addr=0, rr_ptr=0, order queue empty (count=0), all outstanding counters=0.
  - While rst=1, all outputs are 0: read_addr_write, read_addr_din, req_addr_read, resp_data_empty_n, read_data_read.
  - Reset mid-operation discards queue contents. async_mmap must be reset in the same cycle.
- Eligibility: port i is eligible when req_addr_empty_n[i]=1 and outstanding[i] < MaxOutstanding.
- Issue-stage capacity: cap = (!out_valid || read_addr_full_n) && (queue count < TagDepth).
- Grant: when cap=1 and any port is eligible, grant the first eligible port searching rr_ptr, rr_ptr+1, ... modulo NumPorts. Same cycle:
  - req_addr_read[g]=1, combinational.
  - out_addr <= that port's address; out_valid <= 1.
  - g is pushed to the order queue.
  - outstanding[g] increments.
  - rr_ptr <= (g+1) mod NumPorts.
- No grant: if read_addr_full_n=1 and out_valid=1, then out_valid <= 0. rr_ptr is unchanged.
- Issue side: read_addr_write=out_valid, read_addr_din=out_addr. Address latency is 1 cycle from pop to read_addr_write.
- Back-to-back: back-to-back grants sustain 1 address per cycle while read_addr_full_n=1.
- Response steering (combinational): head = order-queue head; hv = (count != 0) && read_data_empty_n.
  - resp_data_empty_n[p] = hv && (head == p).
  - resp_data_dout = read_data_dout.
  - read_data_read = hv && resp_data_read[head].
  - On a pop: the order queue pops and outstanding[head] decrements.
  - resp_data_read on a non-head port is ignored.
- Simultaneous grant and pop:
  - Queue count is unchanged.
  - If g == head, that outstanding counter is unchanged.
  - Push and pop at full are allowed only when the pop frees the slot. cap uses count before the pop, so no grant occurs at full.
- Order queue: circular buffer of PortIdWidth-bit entries, TagDepthLog-bit pointers wrapping naturally, count of TagDepthLog+1 bits.
- Invariants:
  - count equals the sum of outstanding counters, and count <= TagDepth.
  - read_data_empty_n=1 with count=0 is a protocol error: data is not popped.

Test Plan:
- Single port 0 requests 0x1000 -> read_addr_write=1 with din=0x1000 the next cycle. Returned beat 0xAB..: resp_data_empty_n=4'b0001. Pop -> outstanding[0]=0.
- All 4 ports continuously valid, full_n=1 -> grant order 0,1,2,3,0,1 on consecutive cycles; 1 address/cycle.
- read_addr_full_n=0 for 5 cycles with out_valid=1 -> no grants, req_addr_read=0, din held stable. full_n=1 -> grants resume from rr_ptr.
- Port 2 only, MaxOutstanding=16, no responses -> exactly 16 grants, then req_addr_read[2]=0. One response popped -> one more grant.
- Interleaved ports 1,3,1 issued; responses D0,D1,D2 -> D0 to port 1, D1 to port 3, D2 to port 1. resp_data_read[3] asserted while head=1 has no effect.
- Assert rst with 10 outstanding -> immediately all outputs 0, count=0. After release, first grant goes to port 0 when all ports are valid.
